// File: rtl/terminal_arbiter.sv
// Round-robin write arbiter for an 80x30 terminal character buffer,
// with a full-buffer clear sweep that takes priority over requesters.
module terminal_arbiter #(
  parameter int          TERMINAL_ADDR_MAX = 2399,
  parameter logic [7:0]  CLEAR_CHAR        = 8'h20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  input  logic [35:0] req_addr,
  input  logic [23:0] req_data,
  output logic [2:0]  req_ready,
  input  logic        clear_req,
  output logic [11:0] terminal_addr,
  output logic        terminal_write,
  output logic [7:0]  terminal_data,
  output logic        busy,
  output logic        clear_done,
  output logic        addr_error
);

  localparam logic [11:0] ADDR_MAX = 12'(TERMINAL_ADDR_MAX);

  typedef enum logic {ARB, CLEAR} state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [11:0] cnt_q, cnt_d;
  logic [11:0] taddr_q, taddr_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        twrite_q, twrite_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [2:0]  gnt;
  logic [1:0]  gidx;
  logic        found;
  logic [11:0] sel_addr;
  logic [7:0]  sel_data;

  // Requester index reached k steps after pointer p, modulo 3.
  function automatic logic [1:0] rr_idx(input logic [1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= 3) s = s - 3;
    return 2'(s);
  endfunction

  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    if (state_q == ARB && !reset && !clear_req) begin
      for (int k = 0; k < 3; k++) begin
        if (!found && req_valid[rr_idx(ptr_q, k)]) begin
          found            = 1'b1;
          gidx             = rr_idx(ptr_q, k);
          gnt[gidx]        = 1'b1;
        end
      end
    end
  end

  assign sel_addr = req_addr[12*int'(gidx) +: 12];
  assign sel_data = req_data[8*int'(gidx) +: 8];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    taddr_d  = taddr_q;
    tdata_d  = tdata_q;
    twrite_d = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      ARB: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (found) begin
          ptr_d = rr_idx(gidx, 1);
          // Out-of-range writes are consumed but never reach the buffer.
          if (sel_addr > ADDR_MAX) begin
            err_d = 1'b1;
          end else begin
            taddr_d  = sel_addr;
            tdata_d  = sel_data;
            twrite_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        taddr_d  = cnt_q;
        tdata_d  = CLEAR_CHAR;
        twrite_d = 1'b1;
        cnt_d    = cnt_q + 12'd1;
        if (cnt_q == ADDR_MAX) begin
          state_d = ARB;
          done_d  = 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ARB;
      ptr_q    <= '0;
      cnt_q    <= '0;
      taddr_q  <= '0;
      tdata_q  <= '0;
      twrite_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      taddr_q  <= taddr_d;
      tdata_q  <= tdata_d;
      twrite_q <= twrite_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign req_ready      = gnt;
  assign terminal_addr  = taddr_q;
  assign terminal_data  = tdata_q;
  assign terminal_write = twrite_q;
  assign busy           = (state_q == CLEAR);
  assign clear_done     = done_q;
  assign addr_error     = err_q;

endmodule

// File: tb/tb_terminal_arbiter.sv
// Directed bench for terminal_arbiter: table-driven arbitration vectors
// plus hand-written clear-sweep and reset sequences.
module tb_terminal_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [35:0] req_addr;
  logic [23:0] req_data;
  logic [2:0]  req_ready;
  logic        clear_req;
  logic [11:0] terminal_addr;
  logic        terminal_write;
  logic [7:0]  terminal_data;
  logic        busy;
  logic        clear_done;
  logic        addr_error;

  int tests = 0;
  int fails = 0;

  terminal_arbiter dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .clear_req(clear_req),
    .terminal_addr(terminal_addr), .terminal_write(terminal_write),
    .terminal_data(terminal_data), .busy(busy), .clear_done(clear_done),
    .addr_error(addr_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  valid;
    logic [35:0] addr;
    logic [23:0] data;
    logic [2:0]  exp_ready;
    logic        exp_w;
    logic [11:0] exp_a;
    logic [7:0]  exp_d;
    logic        exp_err;
  } vec_t;

  vec_t vt[7];

  initial begin
    int nw, serr, extra;
    bit done;

    // Pointer starts at 0 after reset; expectations track it across rows.
    vt[0] = '{3'b001, {12'd0,   12'd0,    12'd85},   {8'h00, 8'h00, 8'h41}, 3'b001, 1'b1, 12'd85,   8'h41, 1'b0};
    vt[1] = '{3'b000, {12'd7,   12'd7,    12'd7},    {8'h11, 8'h11, 8'h11}, 3'b000, 1'b0, 12'd85,   8'h41, 1'b0};
    vt[2] = '{3'b101, {12'd300, 12'd200,  12'd100},  {8'h43, 8'h42, 8'h41}, 3'b100, 1'b1, 12'd300,  8'h43, 1'b0};
    vt[3] = '{3'b110, {12'd301, 12'd201,  12'd101},  {8'h63, 8'h62, 8'h61}, 3'b010, 1'b1, 12'd201,  8'h62, 1'b0};
    vt[4] = '{3'b011, {12'd302, 12'd202,  12'd102},  {8'h73, 8'h72, 8'h71}, 3'b001, 1'b1, 12'd102,  8'h71, 1'b0};
    vt[5] = '{3'b001, {12'd0,   12'd0,    12'd2400}, {8'h00, 8'h00, 8'h5A}, 3'b001, 1'b0, 12'd102,  8'h71, 1'b1};
    vt[6] = '{3'b010, {12'd0,   12'd2399, 12'd0},    {8'h00, 8'h7E, 8'h00}, 3'b010, 1'b1, 12'd2399, 8'h7E, 1'b1};

    reset = 1'b1; req_valid = 3'b111; req_addr = '0; req_data = '0; clear_req = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_write", terminal_write, 0);
    chk("rst_addr", terminal_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", addr_error, 0);
    reset = 1'b0; req_valid = 3'b000;

    for (int i = 0; i < 7; i++) begin
      req_valid = vt[i].valid; req_addr = vt[i].addr; req_data = vt[i].data;
      #1;
      chk($sformatf("v%0d_ready", i), req_ready, vt[i].exp_ready);
      @(posedge clock); #1;
      chk($sformatf("v%0d_write", i), terminal_write, vt[i].exp_w);
      chk($sformatf("v%0d_addr", i), terminal_addr, vt[i].exp_a);
      chk($sformatf("v%0d_data", i), terminal_data, vt[i].exp_d);
      chk($sformatf("v%0d_err", i), addr_error, vt[i].exp_err);
    end

    // All three requesting continuously from reset: strict rotation.
    reset = 1'b1; req_valid = 3'b111;
    req_addr = {12'd12, 12'd11, 12'd10}; req_data = {8'hC2, 8'hC1, 8'hC0};
    @(posedge clock); #1;
    chk("rst2_err", addr_error, 0);
    chk("rst2_addr", terminal_addr, 0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("rr%0d_ready", k), req_ready, 3'b001 << (k % 3));
      @(posedge clock); #1;
      chk($sformatf("rr%0d_write", k), terminal_write, 1);
      chk($sformatf("rr%0d_addr", k), terminal_addr, 10 + (k % 3));
    end

    // Clear beats a simultaneous request; mid-sweep clear_req is ignored.
    reset = 1'b1; req_valid = 3'b000;
    @(posedge clock); #1;
    reset = 1'b0;
    req_valid = 3'b010; req_addr = {12'd0, 12'd100, 12'd0}; req_data = {8'h00, 8'h55, 8'h00};
    clear_req = 1'b1;
    #1;
    chk("clr_ready0", req_ready, 0);
    @(posedge clock); #1;
    clear_req = 1'b0;
    chk("clr_busy", busy, 1);
    chk("clr_first_w", terminal_write, 0);
    nw = 0; serr = 0; done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clock); #1;
      if (terminal_write) begin
        if (terminal_addr !== nw[11:0] || terminal_data !== 8'h20) serr++;
        nw++;
      end else serr++;
      if (clear_done) begin
        done = 1;
        chk("done_addr", terminal_addr, 2399);
        chk("done_busy", busy, 0);
        chk("done_ready", req_ready, 3'b010);
      end else if (req_ready !== 3'b000 || busy !== 1'b1) serr++;
      clear_req = (nw == 1000);
    end
    clear_req = 1'b0;
    chk("sweep_done_seen", done, 1);
    chk("sweep_count", nw, 2400);
    chk("sweep_errors", serr, 0);
    @(posedge clock); #1;
    req_valid = 3'b000;
    chk("post_w", terminal_write, 1);
    chk("post_addr", terminal_addr, 100);
    chk("post_data", terminal_data, 8'h55);
    extra = 0;
    repeat (4) begin
      @(posedge clock); #1;
      if (clear_done || terminal_write || busy) extra++;
    end
    chk("post_quiet", extra, 0);

    // Reset after 100 sweep writes aborts the clear.
    clear_req = 1'b1;
    @(posedge clock); #1;
    clear_req = 1'b0;
    nw = 0;
    for (int c = 0; c < 200 && nw < 100; c++) begin
      @(posedge clock); #1;
      if (terminal_write) nw++;
    end
    chk("abort_pre_count", nw, 100);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("abort_write", terminal_write, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr", terminal_addr, 0);
    chk("abort_data", terminal_data, 0);
    chk("abort_done", clear_done, 0);
    reset = 1'b0;
    extra = 0;
    repeat (5) begin
      @(posedge clock); #1;
      if (clear_done || terminal_write || busy) extra++;
    end
    chk("abort_quiet", extra, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
